// File: rtl/ak_adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder family.
// Holds the default geometry plus the stage-count and segment-offset helpers.
package ak_adder_pkg;

  localparam int DEFAULT_WIDTH     = 32;
  localparam int DEFAULT_SEG_WIDTH = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  function automatic int calc_stages(input int width, input int seg_width);
    return width / seg_width;
  endfunction

  // Bit offset of the least significant bit of segment idx.
  function automatic int seg_lsb(input int idx, input int seg_width);
    return idx * seg_width;
  endfunction

endpackage

// File: rtl/ak_seg_stage.sv
// One pipeline stage of the segmented adder: adds one SEG_WIDTH slice plus carry-in
// and registers the slice sum, carry-out and valid bit whenever the pipe advances.
module ak_seg_stage
  import ak_adder_pkg::*;
#(
  parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 in_valid,
  input  logic [SEG_WIDTH-1:0] a,
  input  logic [SEG_WIDTH-1:0] b,
  input  logic                 cin,
  output logic [SEG_WIDTH-1:0] sum,
  output logic                 cout,
  output logic                 out_valid
);

  logic [SEG_WIDTH:0] raw;

  assign raw = {1'b0, a} + {1'b0, b} + {{SEG_WIDTH{1'b0}}, cin};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (en) begin
      sum       <= raw[SEG_WIDTH-1:0];
      cout      <= raw[SEG_WIDTH];
      out_valid <= in_valid;
    end
  end

endmodule

// File: rtl/ak_pipe_adder.sv
// Pipelined carry-segmented adder/subtractor with valid/ready on both sides, one segment per stage.
// Optional signed-overflow output is enabled by defining AK_PIPE_OVF_EN.
module ak_pipe_adder
  import ak_adder_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SEG_WIDTH = DEFAULT_SEG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             Ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             Co
`ifdef AK_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int STAGES = calc_stages(WIDTH, SEG_WIDTH);

  if (WIDTH % SEG_WIDTH != 0) begin : g_width_check
    $error("ak_pipe_adder: WIDTH must be a multiple of SEG_WIDTH");
  end

  logic             advance;
  logic             accept;
  logic             cin0;
  logic [WIDTH-1:0] b_op;
  op_e              op;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign accept   = in_valid && advance;
  assign op       = sub ? OP_SUB : OP_ADD;
  assign b_op     = (op == OP_SUB) ? ~Y : Y;
  assign cin0     = (op == OP_SUB) ? 1'b1 : Ci;

  for (genvar k = 0; k < STAGES; k++) begin : g_lvl
    logic [SEG_WIDTH-1:0] a_seg;
    logic [SEG_WIDTH-1:0] b_seg;
    logic [SEG_WIDTH-1:0] seg_sum;
    logic                 c_in;
    logic                 v_in;
    logic                 c_out;
    logic                 v_out;

    if (k == 0) begin : g_src
      assign a_seg = X[SEG_WIDTH-1:0];
      assign b_seg = b_op[SEG_WIDTH-1:0];
      assign c_in  = cin0;
      assign v_in  = accept;
    end else begin : g_src
      assign a_seg = g_lvl[k-1].g_skew.x_hi[SEG_WIDTH-1:0];
      assign b_seg = g_lvl[k-1].g_skew.b_hi[SEG_WIDTH-1:0];
      assign c_in  = g_lvl[k-1].c_out;
      assign v_in  = g_lvl[k-1].v_out;
    end

    ak_seg_stage #(
      .SEG_WIDTH (SEG_WIDTH)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (advance),
      .in_valid  (v_in),
      .a         (a_seg),
      .b         (b_seg),
      .cin       (c_in),
      .sum       (seg_sum),
      .cout      (c_out),
      .out_valid (v_out)
    );

    // Skew: operand bits not yet added ride alongside this stage, next segment in the low bits.
    if (k < STAGES - 1) begin : g_skew
      localparam int HI_W = WIDTH - seg_lsb(k + 1, SEG_WIDTH);
      logic [HI_W-1:0] x_hi;
      logic [HI_W-1:0] b_hi;
      logic [HI_W-1:0] x_src;
      logic [HI_W-1:0] b_src;

      if (k == 0) begin : g_from_port
        assign x_src = X[WIDTH-1:SEG_WIDTH];
        assign b_src = b_op[WIDTH-1:SEG_WIDTH];
      end else begin : g_from_prev
        assign x_src = g_lvl[k-1].g_skew.x_hi[HI_W+SEG_WIDTH-1:SEG_WIDTH];
        assign b_src = g_lvl[k-1].g_skew.b_hi[HI_W+SEG_WIDTH-1:SEG_WIDTH];
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          x_hi <= '0;
          b_hi <= '0;
        end else if (advance) begin
          x_hi <= x_src;
          b_hi <= b_src;
        end
      end
    end

    // Deskew: finished lower sum segments ride along so a beat's sum bits leave together.
    if (k > 0) begin : g_lo
      localparam int LO_W = seg_lsb(k, SEG_WIDTH);
      logic [LO_W-1:0] lo_sum;
      logic [LO_W-1:0] lo_src;

      if (k == 1) begin : g_first_lo
        assign lo_src = g_lvl[0].seg_sum;
      end else begin : g_more_lo
        assign lo_src = {g_lvl[k-1].seg_sum, g_lvl[k-1].g_lo.lo_sum};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lo_sum <= '0;
        end else if (advance) begin
          lo_sum <= lo_src;
        end
      end
    end
  end

  assign out_valid = g_lvl[STAGES-1].v_out;
  assign Co        = g_lvl[STAGES-1].c_out;

  if (STAGES == 1) begin : g_out_single
    assign sum = g_lvl[0].seg_sum;
  end else begin : g_out_multi
    assign sum = {g_lvl[STAGES-1].seg_sum, g_lvl[STAGES-1].g_lo.lo_sum};
  end

`ifdef AK_PIPE_OVF_EN
  logic a_msb_q;
  logic b_msb_q;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit, so only the operand MSBs need keeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
    end else if (advance) begin
      a_msb_q <= g_lvl[STAGES-1].a_seg[SEG_WIDTH-1];
      b_msb_q <= g_lvl[STAGES-1].b_seg[SEG_WIDTH-1];
    end
  end

  assign ovf = a_msb_q ^ b_msb_q ^ sum[WIDTH-1] ^ Co;
`endif

endmodule
